bus_arbiter: RTL

Two-master, one-slave arbiter for the STB/ACK data bus. Master 0 is the CPU data port; master 1 is a second bus master (DMA or debug loader). The block grants the single slave bus to one master at a time with round-robin fairness and holds each grant until the slave acknowledges. A watchdog terminates any transfer the slave never acknowledges, so the CPU cannot stall forever.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_watchdog.sv | 63 ++++++
 rtl/bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus constants and arbiter state encoding
// Purpose: common width, default error data and FSM encoding for the
//          STB/ACK bus arbiter and its watchdog.
// Ports:   none (package).
package bus_arbiter_pkg;

    localparam int BUS_W = 32;

    localparam logic [BUS_W-1:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - transfer watchdog: wait counter, timeout strobe, error address capture
// Purpose: counts granted cycles without a slave ack and forces termination
//          of the transfer in its TIMEOUT-th granted cycle.
// Ports:   clk, reset_n       clock, asynchronous active-low reset
//          active             a grant is held with the master strobe high
//          ack                slave acknowledge
//          addr               slave address of the current transfer
//          timeout_hit        forced termination this cycle
//          err                one-cycle error pulse (same cycle as timeout_hit)
//          err_addr           address of the most recent timed-out transfer
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             active,
    input  logic             ack,
    input  logic [BUS_W-1:0] addr,
    output logic             timeout_hit,
    output logic             err,
    output logic [BUS_W-1:0] err_addr
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0]    count_q, count_d;
    logic [BUS_W-1:0] err_addr_q, err_addr_d;

    // A real ack in the final cycle wins over the timeout.
    assign timeout_hit = active & (count_q == LAST_CNT) & ~ack;
    assign err         = timeout_hit;
    assign err_addr    = err_addr_q;

    // Any end of the granted phase (idle, abort, ack, timeout) clears the
    // counter, so the next grant always starts counting from zero even on a
    // direct hand-off between masters.
    always_comb begin
        count_d    = count_q;
        err_addr_d = err_addr_q;
        if (!active || ack || timeout_hit) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
        if (timeout_hit) begin
            err_addr_d = addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            err_addr_q <= '0;
        end else begin
            count_q    <= count_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin STB/ACK bus arbiter with watchdog
// Purpose: grants one slave bus to master 0 (CPU) or master 1 (DMA/debug),
//          holds the grant until ack or timeout, alternates on contention.
// Ports:   clk, reset_n                         clock, async active-low reset
//          mK_stb/we/addr/dout (K=0,1)          master requests
//          mK_ack/din                           master responses
//          s_stb/we/addr/dout, s_din/s_ack      slave bus
//          err, err_addr                        timeout pulse and address
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int               TIMEOUT  = 16,
    parameter logic [BUS_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [BUS_W-1:0] m0_addr,
    input  logic [BUS_W-1:0] m0_dout,
    output logic             m0_ack,
    output logic [BUS_W-1:0] m0_din,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [BUS_W-1:0] m1_addr,
    input  logic [BUS_W-1:0] m1_dout,
    output logic             m1_ack,
    output logic [BUS_W-1:0] m1_din,
    output logic             s_stb,
    output logic             s_we,
    output logic [BUS_W-1:0] s_addr,
    output logic [BUS_W-1:0] s_dout,
    input  logic [BUS_W-1:0] s_din,
    input  logic             s_ack,
    output logic             err,
    output logic [BUS_W-1:0] err_addr
);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;   // master served most recently
    logic             active;
    logic             timeout_hit;
    logic             done;
    logic [BUS_W-1:0] rd_data;

    assign active  = ((state_q == ST_GNT0) & m0_stb) | ((state_q == ST_GNT1) & m1_stb);
    assign done    = s_ack | timeout_hit;
    assign rd_data = timeout_hit ? ERR_DATA : s_din;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (active),
        .ack         (s_ack),
        .addr        (s_addr),
        .timeout_hit (timeout_hit),
        .err         (err),
        .err_addr    (err_addr)
    );

    // Slave mux and master responses, all driven from the registered grant.
    always_comb begin
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_dout = '0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        m0_din = '0;
        m1_din = '0;
        case (state_q)
            ST_GNT0: begin
                s_stb  = m0_stb;
                s_we   = m0_we;
                s_addr = m0_addr;
                s_dout = m0_dout;
                m0_ack = done;
                m0_din = rd_data;
            end
            ST_GNT1: begin
                s_stb  = m1_stb;
                s_we   = m1_we;
                s_addr = m1_addr;
                s_dout = m1_dout;
                m1_ack = done;
                m1_din = rd_data;
            end
            default: ;
        endcase
    end

    // A completing master never stays granted: it goes to IDLE or hands off,
    // so a CPU strobe still high after its ack cannot ride a stale grant.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_stb && m1_stb) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0_stb) begin
                    state_d = ST_GNT0;
                end else if (m1_stb) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (done) begin
                    last_d  = 1'b0;
                    state_d = m1_stb ? ST_GNT1 : ST_IDLE;
                end else if (!m0_stb) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (done) begin
                    last_d  = 1'b1;
                    state_d = m0_stb ? ST_GNT0 : ST_IDLE;
                end else if (!m1_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
